// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: next-PC select encodings,
// reset/NOP defaults and instruction field widths.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pc_src_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    localparam int unsigned JIDX_W = 26;

    // J-type target: region bits from the ID instruction's PC+4, word index from the instruction.
    function automatic logic [31:0] jump_target(input logic [31:0]       pc_plus4,
                                                 input logic [JIDX_W-1:0] jidx);
        return {pc_plus4[31:28], jidx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_mux.sv
// Next-PC computation for the IF stage: branch, jump and jump-register
// targets plus the 4:1 select driven by the ID-stage controller.
module next_pc_mux
    import fetch_stage_pkg::*;
(
    input  logic [1:0]        pc_src,
    input  logic [31:0]       pc_plus4,
    input  logic [31:0]       if_id_pc_plus4,
    input  logic [JIDX_W-1:0] if_id_jidx,
    input  logic [31:0]       branch_imm,
    input  logic [31:0]       jr_target,
    output logic [31:0]       next_pc
);

    logic [31:0] branch_target;

    assign branch_target = if_id_pc_plus4 + (branch_imm << 2);

    // Select the next PC according to the controller's redirect request.
    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PC_SEQ:  next_pc = pc_plus4;
            PC_BR:   next_pc = branch_target;
            PC_J:    next_pc = jump_target(if_id_pc_plus4, if_id_jidx);
            PC_JR:   next_pc = jr_target;
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the pipelined MIPS core: PC register and IF/ID pipeline
// register. Optional performance counters enabled by FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_src,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] branch_imm,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    next_pc_mux u_next_pc_mux (
        .pc_src         (pc_src),
        .pc_plus4       (pc_plus4),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_jidx     (if_id_instr[JIDX_W-1:0]),
        .branch_imm     (branch_imm),
        .jr_target      (jr_target),
        .next_pc        (next_pc)
    );

    // PC and IF/ID register: reset dominates, stall holds, flush inserts a NOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else if (!stall) begin
            pc             <= next_pc;
            if_id_pc_plus4 <= pc_plus4;
            if (flush) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end else begin
                if_id_instr <= imem_rdata;
                if_id_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Count fetched and flushed cycles; stalled cycles count as neither.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else if (!stall) begin
            if (flush) flush_cnt <= flush_cnt + 32'd1;
            else       fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized redirect/stall/flush/reset traffic against a behavioural model.
// Counter checks are active when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_src;
    logic        flush;
    logic        stall;
    logic [31:0] branch_imm;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    // Instruction memory: fixed hash of the address, optionally overridden.
    logic        ovr_en   = 1'b0;
    logic [31:0] ovr_word = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = ovr_en ? ovr_word : mem_word(imem_addr);

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_src         (pc_src),
        .flush          (flush),
        .stall          (stall),
        .branch_imm     (branch_imm),
        .jr_target      (jr_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_ppc4;
    logic        m_valid;
    logic [31:0] m_fetch, m_flush;

    task automatic model_edge(input logic r, input logic s, input logic f, input logic [1:0] src,
                              input logic [31:0] bimm, input logic [31:0] jrt);
        logic [31:0] fetched;
        logic [31:0] tgt;
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_ppc4 = 32'h0; m_valid = 1'b0;
            m_fetch = 0; m_flush = 0;
        end else if (!s) begin
            fetched = ovr_en ? ovr_word : mem_word(m_pc);
            case (src)
                2'd0:    tgt = m_pc + 32'd4;
                2'd1:    tgt = m_ppc4 + bimm * 32'd4;
                2'd2:    tgt = {m_ppc4[31:28], m_instr[25:0], 2'b00};
                default: tgt = jrt;
            endcase
            m_ppc4 = m_pc + 32'd4;
            if (f) begin
                m_instr = 32'h0; m_valid = 1'b0; m_flush = m_flush + 1;
            end else begin
                m_instr = fetched; m_valid = 1'b1; m_fetch = m_fetch + 1;
            end
            m_pc = tgt;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic [1:0] src,
                        input logic [31:0] bimm, input logic [31:0] jrt);
        rst = r; stall = s; flush = f; pc_src = src; branch_imm = bimm; jr_target = jrt;
        @(posedge clk);
        model_edge(r, s, f, src, bimm, jrt);
        #1;
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("if_id_instr", if_id_instr, m_instr);
        check_eq("if_id_pc_plus4", if_id_pc_plus4, m_ppc4);
        check_eq("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
`ifdef FETCH_PERF_CNT_EN
        check_eq("fetch_cnt", fetch_cnt, m_fetch);
        check_eq("flush_cnt", flush_cnt, m_flush);
`endif
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 2'd0; branch_imm = '0; jr_target = '0;

        // Reset and sequential fetch
        step(1, 0, 0, 2'd0, 0, 0);
        check_eq("rst_pc", imem_addr, 32'h0);
        check_eq("rst_valid", {31'b0, if_id_valid}, 32'h0);
        step(0, 0, 0, 2'd0, 0, 0);
        check_eq("seq_pc1", imem_addr, 32'h4);
        check_eq("seq_ppc4_1", if_id_pc_plus4, 32'h4);
        check_eq("seq_valid1", {31'b0, if_id_valid}, 32'h1);
        step(0, 0, 0, 2'd0, 0, 0);
        check_eq("seq_pc2", imem_addr, 32'h8);
        step(0, 0, 0, 2'd0, 0, 0);
        check_eq("seq_pc3", imem_addr, 32'hC);
        step(0, 0, 0, 2'd0, 0, 0);
        check_eq("seq_ppc4_4", if_id_pc_plus4, 32'h10);

        // Backward branch with flush
        step(0, 0, 1, 2'd1, 32'hFFFF_FFFE, 0);
        check_eq("br_pc", imem_addr, 32'h8);
        check_eq("br_instr", if_id_instr, 32'h0);
        check_eq("br_valid", {31'b0, if_id_valid}, 32'h0);

        // Jump using the ID instruction's index and PC+4 region
        ovr_en = 1'b1; ovr_word = 32'h0800_0040;
        step(0, 0, 1, 2'd3, 0, 32'hA000_0000);
        step(0, 0, 0, 2'd0, 0, 0);
        check_eq("j_ppc4", if_id_pc_plus4, 32'hA000_0004);
        step(0, 0, 1, 2'd2, 0, 0);
        check_eq("j_pc", imem_addr, 32'hA000_0100);
        ovr_en = 1'b0;

        // Stall overrides redirect and flush
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 2'd1, 32'h0000_0100, 0);
            check_eq("stall_pc", imem_addr, 32'hA000_0100);
        end
        step(0, 0, 0, 2'd0, 0, 0);
        check_eq("unstall_pc", imem_addr, 32'hA000_0104);
        check_eq("unstall_valid", {31'b0, if_id_valid}, 32'h1);

        // PC wrap and jr low bits passed through
        step(0, 0, 1, 2'd3, 0, 32'hFFFF_FFFC);
        step(0, 0, 0, 2'd0, 0, 0);
        check_eq("wrap_pc", imem_addr, 32'h0);
        check_eq("wrap_ppc4", if_id_pc_plus4, 32'h0);
        step(0, 0, 0, 2'd3, 0, 32'h1234_5677);
        check_eq("jr_lowbits", imem_addr, 32'h1234_5677);

        // Reset during stall and redirect
        step(0, 1, 0, 2'd0, 0, 0);
        step(1, 1, 1, 2'd1, 32'h10, 0);
        check_eq("rst_stall_pc", imem_addr, 32'h0);
        check_eq("rst_stall_valid", {31'b0, if_id_valid}, 32'h0);

`ifdef FETCH_PERF_CNT_EN
        for (int i = 0; i < 5; i++) step(0, 0, 0, 2'd0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 2'd0, 0, 0);
        step(0, 1, 0, 2'd0, 0, 0);
        check_eq("perf_fetch", fetch_cnt, 32'd5);
        check_eq("perf_flush", flush_cnt, 32'd2);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic r, s, f;
            logic [1:0]  src;
            logic [31:0] bimm;
            r    = ($urandom_range(0, 49) == 0);
            s    = ($urandom_range(0, 3) == 0);
            f    = ($urandom_range(0, 4) == 0);
            src  = 2'($urandom_range(0, 3));
            bimm = {{16{1'b0}}, 16'($urandom)};
            if (bimm[15]) bimm[31:16] = 16'hFFFF;
            step(r, s, f, src, bimm, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the pipelined MIPS core. Owns the PC register and the IF/ID pipeline register.
- Consumes the redirect interface that the ID-stage controller drives: pc_src, flush, and a stall from the hazard unit.
- Presents the instruction address to instruction memory, which reads combinationally.
- Delivers instr, pc_plus4 and valid to the ID stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush and on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_src  in  2  next-PC select from the controller: 00 seq, 01 branch, 10 jump, 11 jump-register.
- flush  in  1  kill the instruction currently being fetched (IF/ID gets NOP_INSTR).
- stall  in  1  hazard unit: hold PC and IF/ID.
- branch_imm  in  32  sign-extended 16-bit immediate of the ID-stage instruction.
- jr_target  in  32  register operand (rs) for jump-register.
- imem_addr  out  32  equals pc; combinational from the PC register.
- imem_rdata  in  32  instruction word at imem_addr, same cycle.
- if_id_instr  out  32  registered instruction to ID.
- if_id_pc_plus4  out  32  registered PC+4 of if_id_instr.
- if_id_valid  out  1  1 when if_id_instr is a real fetched instruction.

Behaviour:
- Reset, synchronous: pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0. rst has priority over every other input, including mid-stall and mid-redirect.
- pc_plus4 = pc + 4, 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Branch target = if_id_pc_plus4 + (branch_imm << 2), 32-bit wrap. It is computed from the ID instruction's PC+4, not the IF PC.
- Jump target = {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}.
- jr target = jr_target; bits [1:0] are passed unmodified.
- next_pc by pc_src: 00 pc_plus4, 01 branch target, 10 jump target, 11 jr_target.
- Stall (stall=1): pc, if_id_instr, if_id_pc_plus4 and if_id_valid all hold. pc_src and flush are ignored that cycle. The hazard unit guarantees that ID re-evaluates once the stall drops.
- Normal cycle (stall=0):
  - pc <= next_pc.
  - If flush=1: if_id_instr <= NOP_INSTR, if_id_valid <= 0, if_id_pc_plus4 <= pc_plus4.
  - Otherwise: if_id_instr <= imem_rdata, if_id_pc_plus4 <= pc_plus4, if_id_valid <= 1.
- Redirect without flush (e.g. pc_src=10 with flush=0 on jal) keeps the sequentially fetched instruction in IF/ID (delay-slot semantics). Flush and redirect are independent inputs.
- flush=1 with pc_src=00 is legal: it kills the fetched instruction and PC advances sequentially.
- Latency:
  - Redirect decided in cycle N: the target appears on imem_addr in cycle N+1; the target instruction reaches IF/ID at edge N+2.
  - Flush in cycle N: IF/ID shows NOP from edge N+1.
- imem_addr is a pure function of the pc register, with no combinational path from pc_src.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds two 32-bit output counters: fetch_cnt and flush_cnt.
  - fetch_cnt increments on every non-stall cycle with flush=0.
  - flush_cnt increments on every non-stall cycle with flush=1.
  - Both are cleared by rst and wrap at 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - pc_src encodings PC_SEQ=2'b00, PC_BR=2'b01, PC_J=2'b10, PC_JR=2'b11.
  - Constants NOP_INSTR and RESET_PC defaults.
  - Instruction field widths (JIDX_W=26).
- One sub-module is natural: next_pc_mux, a combinational target computation plus 4:1 select. The PC and IF/ID registers stay in fetch_stage.

Test Plan:
- Reset then run 4 cycles with pc_src=00, stall=0, flush=0 -> imem_addr 0,4,8,C. if_id_valid=0 in the first cycle and 1 after. if_id_pc_plus4=4 after edge 1.
- if_id_pc_plus4=32'h10, branch_imm=32'hFFFF_FFFE, pc_src=01, flush=1 -> next pc=32'h08. if_id_instr=0, if_id_valid=0.
- if_id_pc_plus4=32'hA000_0004, if_id_instr[25:0]=26'h000_0040, pc_src=10 -> pc=32'hA000_0100.
- stall=1 for 3 cycles while pc_src=01 and flush=1 -> pc and all IF/ID outputs unchanged. The first cycle with stall=0 proceeds normally.
- pc=32'hFFFF_FFFC with pc_src=00 -> pc wraps to 0. rst asserted mid-stall -> pc=RESET_PC and if_id_valid=0 on the next edge.
- FETCH_PERF_CNT_EN defined, 5 normal cycles, 2 flush cycles, 1 stall cycle -> fetch_cnt=5, flush_cnt=2.
